// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the single-clock capture FIFO.
// Also holds the error-flag bit positions used by the status register map.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    localparam int unsigned ERR_OVERFLOW_BIT  = 0;
    localparam int unsigned ERR_UNDERFLOW_BIT = 1;
    localparam int unsigned ERR_W             = 2;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so that count can represent DEPTH itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return ptr_width(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Write/read handshake, status and error signals of fifo_sync_param.
interface fifo_sync_param_if
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1024
);
    import fifo_pkg::*;

    localparam int unsigned CW = count_width(DEPTH);

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port array: synchronous write, read port either registered or asynchronous.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 1024,
    parameter bit          REG_READ = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        re,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]           rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (REG_READ) begin : g_reg_read
        logic [DATA_W-1:0] rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[raddr];
            end
        end

        assign rdata = rdata_q;
    end else begin : g_async_read
        // Read enable and reset only matter for the registered port.
        logic unused_reg_port;
        assign unused_reg_port = ^{re, rst_n};
        assign rdata = mem[raddr];
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill level, watermarks, sticky errors and flush.
// Pointer, count, flag and error logic live here; storage is in fifo_ram.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned FWFT      = FIFO_MODE_STD,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = 4
) (
    input logic              clk,
    input logic              rst_n,
    fifo_sync_param_if.slave bus
);

    localparam int unsigned   PW      = ptr_width(DEPTH);
    localparam int unsigned   CW      = count_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_param: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             empty_q, full_q, almost_empty_q, almost_full_q;
    logic             wa, ra;

    // Acceptance uses only the registered flags, so no wr_en/rd_en path reaches a flag.
    always_comb begin
        wa       = 1'b0;
        ra       = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (bus.clr_err) begin
            err_d = '0;
        end
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wa = bus.wr_en && !full_q;
            ra = bus.rd_en && !empty_q;
            if (wa) wr_ptr_d = wr_ptr_q + PW'(1);
            if (ra) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(wa) - CW'(ra);
            // Setting after the clear makes a same-cycle set win.
            if (bus.wr_en && full_q)  err_d[ERR_OVERFLOW_BIT]  = 1'b1;
            if (bus.rd_en && empty_q) err_d[ERR_UNDERFLOW_BIT] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            err_q          <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            err_q          <= err_d;
            empty_q        <= (count_d == '0);
            full_q         <= (count_d == DEPTH_C);
            almost_empty_q <= (count_d <= AE_C);
            almost_full_q  <= (count_d >= AF_C);
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft_valid
        assign bus.rd_valid = !empty_q;
    end else begin : g_std_valid
        logic rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= ra;
            end
        end

        assign bus.rd_valid = rd_valid_q;
    end

    fifo_ram #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .REG_READ (FWFT != FIFO_MODE_FWFT)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wa),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .re    (ra),
        .raddr (rd_ptr_q),
        .rdata (bus.rd_data)
    );

    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.count        = count_q;
    assign bus.overflow     = err_q[ERR_OVERFLOW_BIT];
    assign bus.underflow    = err_q[ERR_UNDERFLOW_BIT];

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a standard-mode and a FWFT-mode FIFO with identical stimulus and checks both
// against a queue model every cycle, plus hand-computed expectations per scenario.
module tb_fifo_sync_param;
    import fifo_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          flush   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] wr_data = '0;
    bit            chk_en  = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DP)) bus_s ();
    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DP)) bus_f ();

    assign bus_s.flush   = flush;
    assign bus_s.wr_en   = wr_en;
    assign bus_s.wr_data = wr_data;
    assign bus_s.rd_en   = rd_en;
    assign bus_s.clr_err = clr_err;
    assign bus_f.flush   = flush;
    assign bus_f.wr_en   = wr_en;
    assign bus_f.wr_data = wr_data;
    assign bus_f.rd_en   = rd_en;
    assign bus_f.clr_err = clr_err;

    fifo_sync_param #(
        .DATA_W(DW), .DEPTH(DP), .FWFT(FIFO_MODE_STD), .AF_THRESH(6), .AE_THRESH(1)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    fifo_sync_param #(
        .DATA_W(DW), .DEPTH(DP), .FWFT(FIFO_MODE_FWFT), .AF_THRESH(6), .AE_THRESH(1)
    ) dut_f (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Model: contents as a queue, plus sticky errors and the last popped word.
    logic [DW-1:0] q[$];
    bit            m_ovf   = 1'b0;
    bit            m_unf   = 1'b0;
    bit            m_sval  = 1'b0;
    logic [DW-1:0] m_sdata = '0;
    int            m_n;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_sval = 0; m_sdata = '0;
        end else begin
            if (clr_err) begin m_ovf = 0; m_unf = 0; end
            m_sval = 0;
            if (flush) begin
                q.delete();
            end else begin
                m_n = q.size();
                if (wr_en && m_n == DP) m_ovf = 1;
                if (rd_en && m_n == 0)  m_unf = 1;
                if (rd_en && m_n != 0) begin m_sdata = q.pop_front(); m_sval = 1; end
                if (wr_en && m_n != DP) q.push_back(wr_data);
            end
        end
    end

    task automatic cmp_common(input string p, input logic [31:0] cnt, input logic e,
                              input logic f, input logic ae, input logic af,
                              input logic ov, input logic un);
        chk({p, ".count"}, cnt, q.size());
        chk({p, ".empty"}, 32'(e), 32'(q.size() == 0));
        chk({p, ".full"}, 32'(f), 32'(q.size() == DP));
        chk({p, ".almost_empty"}, 32'(ae), 32'(q.size() <= 1));
        chk({p, ".almost_full"}, 32'(af), 32'(q.size() >= 6));
        chk({p, ".overflow"}, 32'(ov), 32'(m_ovf));
        chk({p, ".underflow"}, 32'(un), 32'(m_unf));
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp_common("std", 32'(bus_s.count), bus_s.empty, bus_s.full, bus_s.almost_empty,
                       bus_s.almost_full, bus_s.overflow, bus_s.underflow);
            cmp_common("fwft", 32'(bus_f.count), bus_f.empty, bus_f.full, bus_f.almost_empty,
                       bus_f.almost_full, bus_f.overflow, bus_f.underflow);
            chk("std.rd_valid", 32'(bus_s.rd_valid), 32'(m_sval));
            chk("std.rd_data", 32'(bus_s.rd_data), 32'(m_sdata));
            chk("fwft.rd_valid", 32'(bus_f.rd_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("fwft.rd_data", 32'(bus_f.rd_data), 32'(q[0]));
        end
    end

    // Called at a falling edge; inputs are held across exactly one rising edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f,
                       input bit c);
        wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c;
        @(negedge clk);
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, ".s.rd_data"}, 32'(bus_s.rd_data), 32'h0);
        chk({p, ".s.rd_valid"}, 32'(bus_s.rd_valid), 32'h0);
        chk({p, ".f.rd_valid"}, 32'(bus_f.rd_valid), 32'h0);
        chk({p, ".empty"}, 32'({bus_s.empty, bus_f.empty}), 32'h3);
        chk({p, ".full"}, 32'({bus_s.full, bus_f.full}), 32'h0);
        chk({p, ".almost_empty"}, 32'({bus_s.almost_empty, bus_f.almost_empty}), 32'h3);
        chk({p, ".almost_full"}, 32'({bus_s.almost_full, bus_f.almost_full}), 32'h0);
        chk({p, ".count"}, 32'({bus_s.count, bus_f.count}), 32'h0);
        chk({p, ".errors"}, 32'({bus_s.overflow, bus_s.underflow, bus_f.overflow,
                                 bus_f.underflow}), 32'h0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0x11..0x18, then one rejected write.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(32'h11 + i), 0, 0, 0);
            if (i == 5) begin
                chk("fill.af_at_6", 32'(bus_s.almost_full), 32'h1);
                chk("fill.count_6", 32'(bus_s.count), 32'd6);
            end
        end
        chk("fill.count_8", 32'(bus_s.count), 32'd8);
        chk("fill.full", 32'(bus_s.full), 32'h1);
        cyc(1, 8'h99, 0, 0, 0);
        chk("ovf.set", 32'(bus_s.overflow), 32'h1);
        chk("ovf.count", 32'(bus_s.count), 32'd8);

        // Drain in order; FWFT shows each head before its pop.
        for (int i = 0; i < 8; i++) begin
            chk("drain.fwft_head", 32'(bus_f.rd_data), 32'h11 + 32'(i));
            cyc(0, '0, 1, 0, 0);
            chk("drain.std_data", 32'(bus_s.rd_data), 32'h11 + 32'(i));
            chk("drain.std_valid", 32'(bus_s.rd_valid), 32'h1);
        end
        chk("drain.empty", 32'(bus_s.empty), 32'h1);
        cyc(0, '0, 1, 0, 0);
        chk("unf.set", 32'(bus_s.underflow), 32'h1);
        cyc(0, '0, 0, 0, 1);
        chk("clr.errors", 32'({bus_s.overflow, bus_s.underflow}), 32'h0);

        // FWFT fall-through of a single word.
        cyc(1, 8'hA5, 0, 0, 0);
        chk("fwft.not_empty", 32'(bus_f.empty), 32'h0);
        chk("fwft.data", 32'(bus_f.rd_data), 32'hA5);
        cyc(0, '0, 0, 0, 0);
        chk("fwft.hold", 32'(bus_f.rd_data), 32'hA5);
        cyc(0, '0, 1, 0, 0);
        chk("fwft.empty_after_pop", 32'(bus_f.empty), 32'h1);

        // Sustained write+read at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cyc(1, 8'(32'h20 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'(32'h30 + i), 1, 0, 0);
            chk("steady.count", 32'(bus_s.count), 32'd3);
            chk("steady.data", 32'(bus_s.rd_data),
                (i < 3) ? 32'h20 + 32'(i) : 32'h30 + 32'(i) - 32'd3);
        end
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0);

        // Write+read on full: read wins, write rejected.
        for (int i = 0; i < 8; i++) cyc(1, 8'(32'h40 + i), 0, 0, 0);
        cyc(1, 8'h77, 1, 0, 0);
        chk("fullrw.count", 32'(bus_s.count), 32'd7);
        chk("fullrw.ovf", 32'(bus_s.overflow), 32'h1);
        chk("fullrw.data", 32'(bus_s.rd_data), 32'h40);
        for (int i = 0; i < 7; i++) cyc(0, '0, 1, 0, 0);
        chk("fullrw.last", 32'(bus_s.rd_data), 32'h47);

        // Write+read on empty: write wins, read rejected.
        cyc(1, 8'h55, 1, 0, 0);
        chk("emptyrw.count", 32'(bus_s.count), 32'd1);
        chk("emptyrw.unf", 32'(bus_s.underflow), 32'h1);
        chk("emptyrw.fwft_data", 32'(bus_f.rd_data), 32'h55);

        // Flush at count 5 with a concurrent write; sticky errors survive it.
        for (int i = 0; i < 4; i++) cyc(1, 8'(32'h60 + i), 0, 0, 0);
        chk("flush.pre_count", 32'(bus_s.count), 32'd5);
        cyc(1, 8'h66, 0, 1, 0);
        chk("flush.count", 32'(bus_s.count), 32'd0);
        chk("flush.empty", 32'(bus_s.empty), 32'h1);
        chk("flush.errors_kept", 32'({bus_s.overflow, bus_s.underflow}), 32'h3);
        cyc(0, '0, 0, 0, 1);
        chk("flush.clr", 32'({bus_s.overflow, bus_s.underflow}), 32'h0);
        cyc(1, 8'h67, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        chk("flush.next_data", 32'(bus_s.rd_data), 32'h67);

        // Asynchronous reset mid-stream at count 4.
        for (int i = 0; i < 4; i++) cyc(1, 8'(32'h70 + i), 0, 0, 0);
        chk("midrst.pre_count", 32'(bus_s.count), 32'd4);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 8'h3C, 0, 0, 0);
        chk("midrst.fwft_data", 32'(bus_f.rd_data), 32'h3C);
        cyc(0, '0, 1, 0, 0);
        chk("midrst.std_data", 32'(bus_s.rd_data), 32'h3C);

        // Underflow set beats a same-cycle clear.
        cyc(0, '0, 1, 0, 1);
        chk("setwins.unf", 32'(bus_s.underflow), 32'h1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO for the traffic-capture datapath. It buffers captured bytes or words between the line-side receiver and the downstream parser. Width, depth, read mode and watermark thresholds are set per instance. Over the 8-bit/1024-entry buffer it adds fill-level reporting, almost-full/almost-empty watermarks, sticky error flags, a synchronous flush and correct simultaneous read/write accounting.

## Interface
- DATA_W, 8: data word width in bits, ≥1.
- DEPTH, 1024: number of entries; power of two, ≥2.
- FWFT, 0: read mode. 0 = standard (registered read), 1 = first-word-fall-through.
- AF_THRESH, DEPTH-4: almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, 4: almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous empty request, one cycle.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read/pop request.
- rd_data  out  DATA_W  read word.
- rd_valid  out  1  FWFT=0: rd_data was loaded by a pop last cycle. FWFT=1: equals !empty.
- empty  out  1  no entries stored.
- full  out  1  count == DEPTH.
- almost_empty  out  1  watermark, see above.
- almost_full  out  1  watermark, see above.
- count  out  $clog2(DEPTH)+1  current fill level.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow/underflow.

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case. count is kept separately, one bit wider.
- Write accepted (wa) = wr_en && !full. Read accepted (ra) = rd_en && !empty. Both use the registered flags from the start of the cycle.
- On a full FIFO, a write is rejected even when a read is accepted in the same cycle. On an empty FIFO, a read is rejected even when a write is accepted in the same cycle.
- count_next = count + wa − ra. When wa and ra are both set, count is unchanged and both pointers advance.
- empty, full, almost_empty and almost_full are registered and derived from count_next. They are valid in the same cycle as the new count.
- FWFT=0: on ra, rd_data <= mem[rd_ptr] at that edge and rd_valid=1 for one cycle. rd_data holds its value otherwise.
- FWFT=1: rd_data = mem[rd_ptr] (asynchronous-read array) whenever !empty, and ra advances to the next word. While empty, rd_data is don't-care.
- overflow sets on wr_en && full. underflow sets on rd_en && empty. clr_err clears both. If set and clear occur in the same cycle, set wins.
- flush clears the pointers and count and sets the flags to their reset state. It has priority over wr_en and rd_en in the same cycle, which are neither accepted nor flagged as errors. Memory contents are not cleared and error flags are unaffected.

## Timing
- Reset values: rd_data=0, rd_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, count=0, overflow=0, underflow=0. Pointers are 0.
- Reset assertion mid-operation discards all contents immediately (asynchronous). The first write is accepted on the first rising edge after rst_n deasserts.
- Write-to-read latency:
  - FWFT=1: empty falls one cycle after the write edge, with rd_data valid in that cycle.
  - FWFT=0: the first pop may be issued in that same cycle, and data appears one cycle after the pop edge.
- Throughput is one write and one read per cycle, sustained, at any fill level between 1 and DEPTH-1.
- Flag update latency is exactly one edge after the accepted operation. There are no combinational paths from wr_en or rd_en to the flags.

## Structure
- Shared package fifo_pkg holds:
  - the clog2-derived width helper constants;
  - the FWFT mode constants (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1);
  - the error-flag bit positions used by the status register map.
- One sub-module, fifo_ram: a simple dual-port array with DATA_W and DEPTH parameters, a synchronous write port, and a read port selectable as registered or asynchronous. All pointer, count, flag and error logic stays in fifo_sync_param.
- Elaboration-time checks reject:
  - DEPTH that is not a power of two;
  - AF_THRESH or AE_THRESH out of range.

## Test plan
Unless stated otherwise, all scenarios use DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1.
- Reset with FWFT=0, then write 0x11..0x18 on consecutive cycles:
  - count reaches 8, full=1, almost_full=1 after the 6th write;
  - a 9th write of 0x99 sets overflow, and count stays 8.
- Pop 8 times with FWFT=0: rd_data = 0x11..0x18, each one cycle after its pop with rd_valid=1; empty=1 after the last pop; a 9th pop sets underflow.
- FWFT=1, write 0xA5 into the empty FIFO: the next cycle shows empty=0 and rd_data=0xA5 with no rd_en; rd_en then gives empty=1 the following cycle.
- Simultaneous wr/rd:
  - at count=3, wr_en and rd_en held high for 20 cycles: count stays 3, and data order is preserved across pointer wrap;
  - at full, wr+rd together: the read is accepted, the write is rejected, overflow=1 and count=7;
  - at empty, wr+rd together: the write is accepted, the read is rejected, underflow=1 and count=1.
- Fill to 5, pulse flush together with wr_en: count=0, empty=1, and the write is not stored; overflow/underflow are unchanged; clr_err then clears them.
- Drop rst_n mid-stream at count=4: all outputs take their reset values immediately; after release, the write/read sequence 0x3C returns 0x3C.
